alu_seq_driver: RTL and testbench

- Sequential front-end for the existing combinational alu. Accepts operand A, operand B and function code F as three consecutive beats on one valid/ready input stream.
- Launches the ALU, registers y and flags t, and returns them on a valid/ready result stream.
- Sits between the operand source (switch/host interface or test harness) and the alu.
- Keeps a wrapping count of completed operations.

---
 rtl/alu_seq_driver_pkg.sv | 26 ++
 rtl/alu_seq_driver_alu.sv | 47 ++++
 rtl/alu_seq_driver.sv | 142 ++++++++++++++
 tb/tb_alu_seq_driver.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_driver_pkg.sv
// Shared constants for the sequential ALU front-end: function codes,
// flag bit positions and the collection/execute state encoding.
package alu_seq_driver_pkg;

    localparam logic [2:0] ALU_SUB = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SLL = 3'd6;
    localparam logic [2:0] ALU_SRA = 3'd7;

    localparam int T_EQ  = 0;
    localparam int T_SLT = 1;
    localparam int T_ULT = 2;

    typedef enum logic [2:0] {
        S_A   = 3'd0,
        S_B   = 3'd1,
        S_F   = 3'd2,
        S_EX  = 3'd3,
        S_OUT = 3'd4
    } state_t;

endpackage

// File: rtl/alu_seq_driver_alu.sv
// Combinational ALU: eight operations on a/b selected by f, plus
// unsigned-less, signed-less and equality flags.
module alu
    import alu_seq_driver_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       t
);

    // Comparison flags packed at their fixed bit positions.
    function automatic logic [2:0] cmp_flags(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] z);
        logic [2:0] r;
        r        = 3'b000;
        r[T_EQ]  = (x == z);
        r[T_SLT] = ($signed(x) < $signed(z));
        r[T_ULT] = (x < z);
        return r;
    endfunction

    // Result mux; shift amount is always the low five bits of b.
    always_comb begin
        y = {WIDTH{1'b0}};
        case (f)
            ALU_SUB: y = a - b;
            ALU_ADD: y = a + b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SRL: y = a >> b[4:0];
            ALU_SLL: y = a << b[4:0];
            ALU_SRA: y = $signed(a) >>> b[4:0];
            default: y = {WIDTH{1'b0}};
        endcase
    end

    // Flags depend only on the operands, not on f.
    always_comb begin
        t = cmp_flags(a, b);
    end

endmodule

// File: rtl/alu_seq_driver.sv
// Sequential ALU front-end: collects A, B, F as three beats on one stream,
// runs the ALU once, and holds the registered result until it is taken.
module alu_seq_driver
    import alu_seq_driver_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_t,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2:0]         f_r;
    logic [WIDTH-1:0]   out_y_r;
    logic [2:0]         out_t_r;
    logic [CNT_W-1:0]   op_count_r;
    logic               in_ready_s;
    logic               accept_s;
    logic [WIDTH-1:0]   alu_y_s;
    logic [2:0]         alu_t_s;

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .a(a_r),
        .b(b_r),
        .f(f_r),
        .y(alu_y_s),
        .t(alu_t_s)
    );

    assign accept_s  = in_valid & in_ready_s;
    assign in_ready  = in_ready_s;
    assign out_valid = (state_r == S_OUT);
    assign busy      = (state_r != S_A);
    assign out_y     = out_y_r;
    assign out_t     = out_t_r;
    assign op_count  = op_count_r;

    // Next state and ready; ready never looks at in_valid, and clear both
    // drops ready and rewinds collection so an offered beat is not taken.
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            S_A: begin
                in_ready_s = ~clear & ~rst;
                if (clear) begin
                    state_s = S_A;
                end else if (accept_s) begin
                    state_s = S_B;
                end else begin
                    state_s = S_A;
                end
            end
            S_B: begin
                in_ready_s = ~clear & ~rst;
                if (clear) begin
                    state_s = S_A;
                end else if (accept_s) begin
                    state_s = S_F;
                end else begin
                    state_s = S_B;
                end
            end
            S_F: begin
                in_ready_s = ~clear & ~rst;
                if (clear) begin
                    state_s = S_A;
                end else if (accept_s) begin
                    state_s = S_EX;
                end else begin
                    state_s = S_F;
                end
            end
            S_EX: begin
                state_s = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_s = S_A;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_A;
            end
        endcase
    end

    // State, operand capture, result capture and completion count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_A;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            f_r        <= 3'b000;
            out_y_r    <= {WIDTH{1'b0}};
            out_t_r    <= 3'b000;
            op_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            case (state_r)
                S_A: begin
                    if (accept_s) a_r <= in_data;
                end
                S_B: begin
                    if (accept_s) b_r <= in_data;
                end
                S_F: begin
                    if (accept_s) f_r <= in_data[2:0];
                end
                S_EX: begin
                    out_y_r <= alu_y_s;
                    out_t_r <= alu_t_s;
                end
                S_OUT: begin
                    if (out_ready) op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                default: begin
                    op_count_r <= op_count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver: a handshake-level model checks every
// cycle, and literal expectations pin individual results.
module tb_alu_seq_driver;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic [2:0]    out_t;
    logic          busy;
    logic [CW-1:0] op_count;

    int tests = 0;
    int fails = 0;

    alu_seq_driver #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_t(out_t),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic [2:0]   t;
    } res_t;

    res_t          exp_q[$];
    int            pos;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          ex_flag;
    logic [CW-1:0] model_cnt;
    logic          chk_en = 1'b0;
    logic [W-1:0]  last_y;
    logic [2:0]    last_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        res_t r;
        int   sh;
        sh = int'(b % 32);
        case (f)
            3'd0: r.y = a - b;
            3'd1: r.y = a + b;
            3'd2: r.y = a & b;
            3'd3: r.y = a | b;
            3'd4: r.y = a ^ b;
            3'd5: r.y = a >> sh;
            3'd6: r.y = a << sh;
            default: r.y = W'($signed(a) >>> sh);
        endcase
        r.t = {a < b, $signed(a) < $signed(b), a == b};
        return r;
    endfunction

    // Mid-cycle model: predicts ready/valid/busy/count, checks, then
    // advances its own view of the upcoming edge.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            pos       = 0;
            ex_flag   = 1'b0;
            model_cnt = '0;
        end else if (chk_en) begin
            logic rdy_m;
            rdy_m = (exp_q.size() == 0) && !clear;
            check("busy", 64'(busy), 64'((pos != 0) || (exp_q.size() != 0)));
            check("in_ready", 64'(in_ready), 64'(rdy_m));
            check("op_count", 64'(op_count), 64'(model_cnt));
            if (ex_flag) begin
                check("out_valid_ex", 64'(out_valid), 64'd0);
                ex_flag = 1'b0;
            end else begin
                check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("out_y", 64'(out_y), 64'(exp_q[0].y));
                    check("out_t", 64'(out_t), 64'(exp_q[0].t));
                    if (out_ready) begin
                        last_y = out_y;
                        last_t = out_t;
                        void'(exp_q.pop_front());
                        model_cnt = model_cnt + 1'b1;
                    end
                end
            end
            if (clear) begin
                pos = 0;
            end else if (in_valid && rdy_m) begin
                if (pos == 0) begin
                    opa = in_data; pos = 1;
                end else if (pos == 1) begin
                    opb = in_data; pos = 2;
                end else begin
                    exp_q.push_back(model(opa, opb, in_data[2:0]));
                    ex_flag = 1'b1;
                    pos = 0;
                end
            end
        end
    end

    // Offer one beat from posedge+1 until the DUT takes it.
    task automatic send_beat(input logic [W-1:0] d);
        bit got = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        if (!got) check("beat_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin done = 1; break; end
        end
        if (!done) check("idle_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid();
        bit done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin done = 1; break; end
        end
        if (!done) check("valid_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    // Upper bits of the F beat carry junk that must be ignored.
    task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        send_beat(a);
        send_beat(b);
        send_beat({29'h15555555, f});
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        send_op(a, b, f);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_out_y", 64'(out_y), 64'd0);
        check("rst_out_t", 64'(out_t), 64'd0);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        out_ready = 1'b1;

        // sub with latency: not valid right after F, valid one edge later
        send_op(32'd5, 32'd11, 3'd0);
        check("lat_ex", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_out", 64'(out_valid), 64'd1);
        wait_idle();
        check("sub_y", 64'(last_y), 64'hFFFFFFFA);
        check("sub_t", 64'(last_t), 64'b110);
        check("sub_cnt", 64'(op_count), 64'd1);

        run_op(32'd3, 32'hFFFFFFFC, 3'd1);
        check("add_y", 64'(last_y), 64'hFFFFFFFF);
        check("add_t", 64'(last_t), 64'b100);
        run_op(32'd6, 32'd6, 3'd4);
        check("xor_y", 64'(last_y), 64'd0);
        check("xor_t", 64'(last_t), 64'b001);

        run_op(32'hA9, 32'd4, 3'd5);
        check("srl_y", 64'(last_y), 64'h0000000A);
        run_op(32'hA9, 32'd4, 3'd6);
        check("sll_y", 64'(last_y), 64'h00000A90);
        run_op(32'hFFFFFFB0, 32'd8, 3'd7);
        check("sra_y", 64'(last_y), 64'hFFFFFFFF);
        check("sra_t", 64'(last_t), 64'b010);

        // backpressure with a junk beat offered throughout
        out_ready = 1'b0;
        send_op(32'hF0, 32'h3C, 3'd3);
        wait_valid();
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_y", 64'(out_y), 64'hFC);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_cnt", 64'(op_count), 64'd7);
        @(posedge clk); #1;
        check("bp_cnt_once", 64'(op_count), 64'd7);
        check("bp_idle", 64'(busy), 64'd0);
        out_ready = 1'b1;

        // clear after A and B, with a beat offered on the clear cycle
        send_beat(32'd100);
        send_beat(32'd200);
        in_valid = 1'b1; in_data = 32'd77; clear = 1'b1;
        @(negedge clk);
        check("clr_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        check("clr_busy", 64'(busy), 64'd0);
        run_op(32'd2, 32'd3, 3'd1);
        check("clr_y", 64'(last_y), 64'd5);
        check("clr_cnt", 64'(op_count), 64'd8);

        // count wrap: seven more to reach all-ones, then one more
        for (int i = 0; i < 7; i++) run_op(W'(i), 32'd1, 3'd1);
        check("cnt_max", 64'(op_count), 64'hF);
        run_op(32'd1, 32'd1, 3'd2);
        check("cnt_wrap", 64'(op_count), 64'd0);
        run_op(32'd1, 32'd1, 3'd1);
        check("cnt_one", 64'(op_count), 64'd1);

        // async reset while holding a result
        out_ready = 1'b0;
        send_op(32'd7, 32'd1, 3'd1);
        wait_valid();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_cnt", 64'(op_count), 64'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        run_op(32'd1, 32'd2, 3'd3);
        check("post_y", 64'(last_y), 64'd3);
        check("post_cnt", 64'(op_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
